// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, default widths and ALU opcode constants for the 8-bit datapath
package cpu_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   localparam int PC_W_DEF   = 10;
   localparam int LUT_AW_DEF = 4;

   localparam logic [2:0] OP_SHIFT    = 3'b001;
   localparam logic [2:0] OP_BNEG     = 3'b010;
   localparam logic [2:0] OP_NOR      = 3'b011;
   localparam logic [2:0] OP_ADD      = 3'b100;
   localparam logic [2:0] OP_ADD_MASK = 3'b100;

   // Masked opcode compare; OP_ADD matches any opcode with the top bit set
   function automatic logic op_match(logic [2:0] op, logic [2:0] pat, logic [2:0] mask);
      return ((op ^ pat) & mask) == 3'b000;
   endfunction

endpackage

// File: rtl/branch_lut.sv
// branch_lut: writable branch/jump target table, async read, sync write, async clear
module branch_lut
   import cpu_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int LUT_AW = LUT_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [LUT_AW-1:0] wr_idx,
   input  logic [PC_W-1:0]   wr_data,
   input  logic [LUT_AW-1:0] rd_idx,
   output logic [PC_W-1:0]   rd_data
);

   logic [PC_W-1:0] mem [2**LUT_AW];

   // Table storage; a read in the same cycle as a write sees the old entry
   always_ff @(posedge clk or posedge rst)
      if (rst) mem <= '{default: '0};
      else if (wr_en) mem[wr_idx] <= wr_data;

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter and control-flow FSM feeding decode and the ALU
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int LUT_AW = LUT_AW_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stall,
   input  logic              Halt_req,
   input  logic              Jump_en,
   input  logic              Branch_en,
   input  logic              Alu_zero,
   input  logic [LUT_AW-1:0] Lut_idx,
   input  logic              Lut_wr_en,
   input  logic [LUT_AW-1:0] Lut_wr_idx,
   input  logic [PC_W-1:0]   Lut_wr_data,
   output logic [PC_W-1:0]   Pc,
   output logic              Pc_valid,
   output logic              Taken,
   output logic              Done
);

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc_nxt, target;
   logic            taken_nxt;

   branch_lut #(.PC_W(PC_W), .LUT_AW(LUT_AW)) u_lut (
      .clk     (Clk),
      .rst     (Reset),
      .wr_en   (Lut_wr_en),
      .wr_idx  (Lut_wr_idx),
      .wr_data (Lut_wr_data),
      .rd_idx  (Lut_idx),
      .rd_data (target)
   );

   // State, PC and registered status flags
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         state <= IDLE;
         Pc    <= '0;
         Taken <= 1'b0;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         Pc    <= pc_nxt;
         Taken <= taken_nxt;
         Done  <= state_nxt == HALTED;
      end

   // Next state and PC: Start overrides everything, then stall, halt, jump, taken branch, increment
   always_comb begin
      state_nxt = state;
      pc_nxt    = Pc;
      taken_nxt = 1'b0;
      if (Start) begin
         state_nxt = RUN;
         pc_nxt    = '0;
      end else if (state == RUN && !Stall) begin
         if (Halt_req) state_nxt = HALTED;
         else if (Jump_en || (Branch_en && Alu_zero)) begin
            pc_nxt    = target;
            taken_nxt = 1'b1;
         end else pc_nxt = Pc + 1'b1;
      end
   end

   // Address is consumable only while running and not frozen
   always_comb Pc_valid = state == RUN && !Stall;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   logic       Clk = 0, Reset = 0, Start = 0, Stall = 0, Halt_req = 0;
   logic       Jump_en = 0, Branch_en = 0, Alu_zero = 0, Lut_wr_en = 0;
   logic [3:0] Lut_idx = 0, Lut_wr_idx = 0;
   logic [9:0] Lut_wr_data = 0, Pc;
   logic       Pc_valid, Taken, Done;
   int         n_cmp = 0, n_err = 0;

   fetch_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt_req(Halt_req),
      .Jump_en(Jump_en), .Branch_en(Branch_en), .Alu_zero(Alu_zero), .Lut_idx(Lut_idx),
      .Lut_wr_en(Lut_wr_en), .Lut_wr_idx(Lut_wr_idx), .Lut_wr_data(Lut_wr_data),
      .Pc(Pc), .Pc_valid(Pc_valid), .Taken(Taken), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_start;
      Start = 1;
      tick();
      Start = 0;
   endtask

   task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
      Lut_wr_en = 1; Lut_wr_idx = idx; Lut_wr_data = data;
      tick();
      Lut_wr_en = 0;
   endtask

   task automatic test_reset;
      Reset = 1;
      #3;
      n_cmp++; if ({Pc, Done, Taken, Pc_valid} !== 13'd0) begin n_err++; $display("FAIL reset_init got pc=%h d=%b t=%b v=%b want 0", Pc, Done, Taken, Pc_valid); end
      Reset = 0;
      tick();
      do_start();
      repeat (7) tick();
      n_cmp++; if (Pc !== 10'd7) begin n_err++; $display("FAIL run_to_7 got %h want 007", Pc); end
      #2 Reset = 1;
      #1;
      n_cmp++; if ({Pc, Done, Taken} !== 12'd0) begin n_err++; $display("FAIL async_reset got pc=%h d=%b t=%b want 0", Pc, Done, Taken); end
      Reset = 0;
      tick();
      Start = 1;
      tick();
      Start = 0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (Pc !== 10'(i) || Pc_valid !== 1'b1) begin n_err++; $display("FAIL count_%0d got pc=%h v=%b want %h 1", i, Pc, Pc_valid, 10'(i)); end
         tick();
      end
   endtask

   task automatic test_idle;
      Reset = 1;
      #1 Reset = 0;
      Jump_en = 1; Branch_en = 1; Alu_zero = 1;
      tick(); tick();
      Jump_en = 0; Branch_en = 0; Alu_zero = 0;
      n_cmp++; if (Pc !== 10'd0 || Taken !== 1'b0 || Pc_valid !== 1'b0) begin n_err++; $display("FAIL idle_ignore got pc=%h t=%b v=%b want 000 0 0", Pc, Taken, Pc_valid); end
   endtask

   task automatic test_branch;
      lut_write(4'd3, 10'h02A);
      do_start();
      repeat (5) tick();
      Branch_en = 1; Alu_zero = 1; Lut_idx = 3;
      tick();
      Branch_en = 0; Alu_zero = 0;
      n_cmp++; if (Pc !== 10'h02A || Taken !== 1'b1) begin n_err++; $display("FAIL branch_taken got pc=%h t=%b want 02a 1", Pc, Taken); end
      tick();
      n_cmp++; if (Pc !== 10'h02B || Taken !== 1'b0) begin n_err++; $display("FAIL taken_pulse got pc=%h t=%b want 02b 0", Pc, Taken); end
      do_start();
      repeat (5) tick();
      Branch_en = 1; Alu_zero = 0;
      tick();
      Branch_en = 0;
      n_cmp++; if (Pc !== 10'd6 || Taken !== 1'b0) begin n_err++; $display("FAIL branch_not_taken got pc=%h t=%b want 006 0", Pc, Taken); end
   endtask

   task automatic test_jump_priority;
      Jump_en = 1; Branch_en = 1; Alu_zero = 0; Lut_idx = 3;
      tick();
      Branch_en = 0;
      n_cmp++; if (Pc !== 10'h02A || Taken !== 1'b1) begin n_err++; $display("FAIL jump_prio got pc=%h t=%b want 02a 1", Pc, Taken); end
      Lut_wr_en = 1; Lut_wr_idx = 3; Lut_wr_data = 10'h010;
      tick();
      Lut_wr_en = 0;
      n_cmp++; if (Pc !== 10'h02A || Taken !== 1'b1) begin n_err++; $display("FAIL read_before_write got pc=%h t=%b want 02a 1", Pc, Taken); end
      tick();
      Jump_en = 0;
      n_cmp++; if (Pc !== 10'h010) begin n_err++; $display("FAIL jump_new_entry got %h want 010", Pc); end
   endtask

   task automatic test_stall_halt;
      do_start();
      repeat (9) tick();
      Stall = 1; Halt_req = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (Pc !== 10'd9 || Pc_valid !== 1'b0 || Done !== 1'b0) begin n_err++; $display("FAIL stall_%0d got pc=%h v=%b d=%b want 009 0 0", i, Pc, Pc_valid, Done); end
      end
      Stall = 0;
      tick();
      n_cmp++; if (Pc !== 10'd9 || Done !== 1'b1 || Pc_valid !== 1'b0) begin n_err++; $display("FAIL halt got pc=%h d=%b v=%b want 009 1 0", Pc, Done, Pc_valid); end
      Halt_req = 0; Jump_en = 1; Branch_en = 1; Alu_zero = 1; Lut_idx = 3;
      tick(); tick();
      Jump_en = 0; Branch_en = 0; Alu_zero = 0;
      n_cmp++; if (Pc !== 10'd9 || Done !== 1'b1 || Taken !== 1'b0) begin n_err++; $display("FAIL halted_hold got pc=%h d=%b t=%b want 009 1 0", Pc, Done, Taken); end
      do_start();
      n_cmp++; if (Pc !== 10'd0 || Done !== 1'b0 || Pc_valid !== 1'b1) begin n_err++; $display("FAIL restart got pc=%h d=%b v=%b want 000 0 1", Pc, Done, Pc_valid); end
   endtask

   task automatic test_wrap;
      lut_write(4'd5, 10'h3FE);
      Jump_en = 1; Lut_idx = 5;
      tick();
      Jump_en = 0;
      n_cmp++; if (Pc !== 10'h3FE || Taken !== 1'b1) begin n_err++; $display("FAIL wrap_setup got pc=%h t=%b want 3fe 1", Pc, Taken); end
      tick();
      n_cmp++; if (Pc !== 10'h3FF || Taken !== 1'b0) begin n_err++; $display("FAIL wrap_3ff got pc=%h t=%b want 3ff 0", Pc, Taken); end
      tick();
      n_cmp++; if (Pc !== 10'h000 || Taken !== 1'b0 || Pc_valid !== 1'b1) begin n_err++; $display("FAIL wrap_000 got pc=%h t=%b v=%b want 000 0 1", Pc, Taken, Pc_valid); end
   endtask

   task automatic test_back_to_back;
      Jump_en = 1; Lut_idx = 3;
      tick();
      Jump_en = 0; Branch_en = 1; Alu_zero = 1; Lut_idx = 5;
      n_cmp++; if (Pc !== 10'h010 || Taken !== 1'b1) begin n_err++; $display("FAIL b2b_first got pc=%h t=%b want 010 1", Pc, Taken); end
      tick();
      Branch_en = 0; Alu_zero = 0;
      n_cmp++; if (Pc !== 10'h3FE || Taken !== 1'b1) begin n_err++; $display("FAIL b2b_second got pc=%h t=%b want 3fe 1", Pc, Taken); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_branch();
      test_jump_priority();
      test_stall_halt();
      test_wrap();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
